alu_cmd_seq: RTL and testbench

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_core.sv | 69 ++++++
 rtl/alu_cmd_seq.sv | 161 ++++++++++++++++
 tb/tb_alu_cmd_seq.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and sequencer state definitions for the ALU command sequencer.
package alu_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_LOAD = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_SLT  = 3'b110,
    OP_EQ   = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_OUT  = 2'b10
  } seq_state_e;

  // Comparisons and LOAD leave the accumulator to the caller; LOAD is bypassed.
  function automatic logic writes_acc(input logic [2:0] op);
    logic w;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: w = 1'b1;
      default:                               w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 4-bit ALU: wrapped result plus zero/signed-overflow/carry flags.
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [2:0] op_i,
  output logic [3:0] res_o,
  output logic       zero_o,
  output logic       over_o,
  output logic       cout_o
);

  logic [4:0] sum_s;
  logic [4:0] diff_s;
  logic       add_ovf_s;
  logic       sub_ovf_s;
  logic       is_cmp_s;

  assign sum_s     = {1'b0, a_i} + {1'b0, b_i};
  assign diff_s    = {1'b0, a_i} + {1'b0, ~b_i} + 5'd1;
  assign add_ovf_s = (a_i[3] == b_i[3]) && (sum_s[3] != a_i[3]);
  assign sub_ovf_s = (a_i[3] != b_i[3]) && (diff_s[3] != a_i[3]);

  // Opcode decode; SLT/EQ report the flags of the underlying a-b subtraction.
  always_comb begin
    res_o    = 4'd0;
    over_o   = 1'b0;
    cout_o   = 1'b0;
    is_cmp_s = 1'b0;
    case (op_i)
      OP_ADD: begin
        res_o  = sum_s[3:0];
        over_o = add_ovf_s;
        cout_o = sum_s[4];
      end
      OP_SUB: begin
        res_o  = diff_s[3:0];
        over_o = sub_ovf_s;
        cout_o = diff_s[4];
      end
      OP_LOAD: res_o = b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_SLT: begin
        res_o    = {3'b000, diff_s[3] ^ sub_ovf_s};
        over_o   = sub_ovf_s;
        cout_o   = diff_s[4];
        is_cmp_s = 1'b1;
      end
      OP_EQ: begin
        res_o    = {3'b000, (diff_s[3:0] == 4'd0)};
        over_o   = sub_ovf_s;
        cout_o   = diff_s[4];
        is_cmp_s = 1'b1;
      end
      default: res_o = 4'd0;
    endcase
    if (op_i == OP_LOAD) begin
      zero_o = 1'b0;
    end else if (is_cmp_s) begin
      zero_o = (diff_s[3:0] == 4'd0);
    end else begin
      zero_o = (res_o == 4'd0);
    end
  end

endmodule

// File: rtl/alu_cmd_seq.sv
// Command sequencer: 2-entry command FIFO feeding an accumulator ALU with a
// valid/ready result register, sticky overflow and a completed-result counter.
module alu_cmd_seq
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_opnd,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_data,
  output logic             res_zero,
  output logic             res_over,
  output logic             res_cout,
  output logic [3:0]       acc,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] done_cnt
);

  logic [2:0]       fifo_op_q   [2];
  logic [3:0]       fifo_opnd_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             push_s, pop_s;

  seq_state_e       state_q;
  logic [2:0]       op_q;
  logic [3:0]       opnd_q, acc_q, res_data_q;
  logic             res_zero_q, res_over_q, res_cout_q, res_valid_q, ovf_q;
  logic [CNT_W-1:0] done_cnt_q;

  logic [3:0]       alu_res_s;
  logic             alu_zero_s, alu_over_s, alu_cout_s;

  alu_core u_alu (
    .a_i    (acc_q),
    .b_i    (opnd_q),
    .op_i   (op_q),
    .res_o  (alu_res_s),
    .zero_o (alu_zero_s),
    .over_o (alu_over_s),
    .cout_o (alu_cout_s)
  );

  assign cmd_ready  = (count_q != 2'd2);
  assign push_s     = cmd_valid && cmd_ready;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_zero   = res_zero_q;
  assign res_over   = res_over_q;
  assign res_cout   = res_cout_q;
  assign acc        = acc_q;
  assign ovf_sticky = ovf_q;
  assign done_cnt   = done_cnt_q;

  // Pop whenever the FSM is free to take the head: idle, or finishing a handshake.
  always_comb begin
    if (count_q == 2'd0) begin
      pop_s = 1'b0;
    end else if (state_q == ST_IDLE) begin
      pop_s = 1'b1;
    end else if (state_q == ST_OUT && res_ready) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Command FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_op_q[wr_ptr_q]   <= cmd_op;
        fifo_opnd_q[wr_ptr_q] <= cmd_opnd;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // Sequencer FSM with accumulator, result register, sticky overflow and counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'd0;
      opnd_q      <= 4'd0;
      acc_q       <= 4'd0;
      res_data_q  <= 4'd0;
      res_zero_q  <= 1'b0;
      res_over_q  <= 1'b0;
      res_cout_q  <= 1'b0;
      res_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      done_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop_s) begin
            op_q    <= fifo_op_q[rd_ptr_q];
            opnd_q  <= fifo_opnd_q[rd_ptr_q];
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_valid_q <= 1'b1;
          state_q     <= ST_OUT;
          if (op_q == OP_LOAD) begin
            res_data_q <= opnd_q;
            res_zero_q <= 1'b0;
            res_over_q <= 1'b0;
            res_cout_q <= 1'b0;
            acc_q      <= opnd_q;
          end else begin
            res_data_q <= alu_res_s;
            res_zero_q <= alu_zero_s;
            res_over_q <= alu_over_s;
            res_cout_q <= alu_cout_s;
            if (alu_over_s) begin
              ovf_q <= 1'b1;
            end
            if (writes_acc(op_q)) begin
              acc_q <= alu_res_s;
            end
          end
        end
        ST_OUT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            done_cnt_q  <= done_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (pop_s) begin
              op_q    <= fifo_op_q[rd_ptr_q];
              opnd_q  <= fifo_opnd_q[rd_ptr_q];
              state_q <= ST_EXEC;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench for alu_cmd_seq: directed table, hand-written corner
// sequences and randomized traffic scored against an arithmetic reference model.
module tb_alu_cmd_seq;
  import alu_pkg::*;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n, cmd_valid, cmd_ready, res_valid, res_ready;
  logic [2:0]       cmd_op;
  logic [3:0]       cmd_opnd, res_data, acc;
  logic             res_zero, res_over, res_cout, ovf_sticky;
  logic [CNT_W-1:0] done_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  bit rand_mode = 1'b0;

  typedef struct {
    logic [3:0] data;
    logic       zero, over, cout;
    logic [3:0] acc;
    logic       sticky;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [3:0] b;
    exp_t       e;
  } vec_t;

  exp_t       exp_q[$];
  int         m_acc = 0;
  logic       m_sticky = 1'b0;
  logic [7:0] m_cnt = 8'd0;
  logic       prev_hold = 1'b0;
  logic [6:0] prev_out = 7'd0;

  always #5 clk = ~clk;

  alu_cmd_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_opnd(cmd_opnd), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero), .res_over(res_over), .res_cout(res_cout),
    .acc(acc), .ovf_sticky(ovf_sticky), .done_cnt(done_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: condition not met within bound", name);
  endtask

  // Reference: plain signed/unsigned integer arithmetic on 4-bit values.
  function automatic exp_t model(input int op, input int a, input int b, input logic sticky_in);
    exp_t e;
    int sa, sb, s, d;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    d  = sa - sb;
    e.data = 4'd0; e.zero = 1'b0; e.over = 1'b0; e.cout = 1'b0; e.acc = 4'(a);
    case (op)
      0: begin
        s = a + b;
        e.data = 4'(s); e.cout = (s > 15); e.over = (sa + sb > 7) || (sa + sb < -8);
        e.zero = (s % 16 == 0); e.acc = e.data;
      end
      1: begin
        e.data = 4'(a - b); e.cout = (a >= b); e.over = (d > 7) || (d < -8);
        e.zero = (a == b); e.acc = e.data;
      end
      2: begin e.data = 4'(b); e.acc = 4'(b); end
      3: begin e.data = 4'(a & b); e.zero = ((a & b) == 0); e.acc = e.data; end
      4: begin e.data = 4'(a | b); e.zero = ((a | b) == 0); e.acc = e.data; end
      5: begin e.data = 4'(a ^ b); e.zero = ((a ^ b) == 0); e.acc = e.data; end
      6: begin
        e.data = {3'b000, (sa < sb)}; e.zero = (a == b); e.cout = (a >= b);
        e.over = (d > 7) || (d < -8);
      end
      default: begin
        e.data = {3'b000, (a == b)}; e.zero = (a == b); e.cout = (a >= b);
        e.over = (d > 7) || (d < -8);
      end
    endcase
    e.sticky = sticky_in | e.over;
    return e;
  endfunction

  // Scoreboard monitor, sampling on the falling edge between driven edges.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      m_acc = 0; m_sticky = 1'b0; m_cnt = 8'd0; prev_hold = 1'b0;
    end else begin
      if (prev_hold && res_valid)
        check("hold_stable", {res_data, res_zero, res_over, res_cout}, prev_out);
      if (res_valid && exp_q.size() == 0) begin
        fail("spurious_result");
      end else if (res_valid && res_ready) begin
        e = exp_q.pop_front();
        check("sb_data",   res_data,   e.data);
        check("sb_zero",   res_zero,   e.zero);
        check("sb_over",   res_over,   e.over);
        check("sb_cout",   res_cout,   e.cout);
        check("sb_acc",    acc,        e.acc);
        check("sb_sticky", ovf_sticky, e.sticky);
        check("sb_cnt",    done_cnt,   m_cnt);
        m_cnt = m_cnt + 8'd1;
      end
      prev_hold = res_valid && !res_ready;
      prev_out  = {res_data, res_zero, res_over, res_cout};
      if (cmd_valid && cmd_ready) begin
        e = model(int'(cmd_op), m_acc, int'(cmd_opnd), m_sticky);
        m_acc = int'(e.acc);
        m_sticky = e.sticky;
        exp_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [3:0] b);
    bit done = 1'b0;
    cmd_op = op; cmd_opnd = b; cmd_valid = 1'b1;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (cmd_ready) done = 1'b1;
      tick();
      if (!done && rand_mode) res_ready = ($urandom_range(0, 3) != 0);
    end
    cmd_valid = 1'b0;
    if (!done) fail("push_timeout");
  endtask

  task automatic drain();
    bit done = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 60 && !done; k++) begin
      tick();
      if (exp_q.size() == 0 && !res_valid) done = 1'b1;
    end
    if (!done) fail("drain_timeout");
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  vec_t tbl[10];
  logic [3:0] held;

  initial begin : stim
    bit ok;
    rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b1; cmd_op = 3'd0; cmd_opnd = 4'd0;
    tbl[0] = '{3'd2, 4'd5,  '{4'd5, 1'b0, 1'b0, 1'b0, 4'd5,  1'b0}};
    tbl[1] = '{3'd0, 4'd3,  '{4'd8, 1'b0, 1'b1, 1'b0, 4'd8,  1'b1}};
    tbl[2] = '{3'd2, 4'd8,  '{4'd8, 1'b0, 1'b0, 1'b0, 4'd8,  1'b1}};
    tbl[3] = '{3'd1, 4'd8,  '{4'd0, 1'b1, 1'b0, 1'b1, 4'd0,  1'b1}};
    tbl[4] = '{3'd2, 4'd2,  '{4'd2, 1'b0, 1'b0, 1'b0, 4'd2,  1'b1}};
    tbl[5] = '{3'd6, 4'd5,  '{4'd1, 1'b0, 1'b0, 1'b0, 4'd2,  1'b1}};
    tbl[6] = '{3'd7, 4'd2,  '{4'd1, 1'b1, 1'b0, 1'b1, 4'd2,  1'b1}};
    tbl[7] = '{3'd5, 4'd15, '{4'd13, 1'b0, 1'b0, 1'b0, 4'd13, 1'b1}};
    tbl[8] = '{3'd3, 4'd2,  '{4'd0, 1'b1, 1'b0, 1'b0, 4'd0,  1'b1}};
    tbl[9] = '{3'd4, 4'd9,  '{4'd9, 1'b0, 1'b0, 1'b0, 4'd9,  1'b1}};

    // Reset values, sampled while reset is still asserted.
    tick(); tick();
    @(negedge clk);
    check("rst_valid",  res_valid,  1'b0);
    check("rst_data",   res_data,   4'd0);
    check("rst_flags",  {res_zero, res_over, res_cout}, 3'd0);
    check("rst_acc",    acc,        4'd0);
    check("rst_sticky", ovf_sticky, 1'b0);
    check("rst_cnt",    done_cnt,   8'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", cmd_ready, 1'b1);
    tick();

    // Two-cycle latency from acceptance to res_valid.
    push(OP_LOAD, 4'd7);
    @(negedge clk); check("lat_n0", res_valid, 1'b0);
    @(negedge clk); check("lat_n1", res_valid, 1'b0);
    @(negedge clk); check("lat_n2", res_valid, 1'b1);
    check("lat_data", res_data, 4'd7);
    drain();

    // Directed table.
    do_reset();
    foreach (tbl[i]) begin
      push(tbl[i].op, tbl[i].b);
      ok = 1'b0;
      for (int k = 0; k < 8 && !ok; k++) begin
        @(negedge clk);
        if (res_valid) ok = 1'b1;
      end
      if (!ok) begin
        fail("tbl_wait");
      end else begin
        check("tbl_data",   res_data,   tbl[i].e.data);
        check("tbl_zero",   res_zero,   tbl[i].e.zero);
        check("tbl_over",   res_over,   tbl[i].e.over);
        check("tbl_cout",   res_cout,   tbl[i].e.cout);
        check("tbl_acc",    acc,        tbl[i].e.acc);
        check("tbl_sticky", ovf_sticky, tbl[i].e.sticky);
      end
      tick();
    end

    // Backpressure: three commands fill the pipeline, a fourth must wait.
    res_ready = 1'b0;
    push(OP_ADD, 4'd1); push(OP_ADD, 4'd2); push(OP_SUB, 4'd3);
    cmd_op = OP_OR; cmd_opnd = 4'd4; cmd_valid = 1'b1;
    @(negedge clk);
    check("bp_full", cmd_ready, 1'b0);
    held = res_data;
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready", cmd_ready, 1'b0);
      check("bp_valid", res_valid, 1'b1);
      check("bp_data",  res_data,  held);
      tick();
    end
    res_ready = 1'b1;
    push(OP_OR, 4'd4);
    drain();

    // Reset while a command executes with another still queued.
    do_reset();
    res_ready = 1'b0;
    push(OP_LOAD, 4'd9); push(OP_ADD, 4'd1); push(OP_ADD, 4'd2);
    res_ready = 1'b1;
    tick();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rst_mid_valid", res_valid, 1'b0);
      tick();
    end
    @(negedge clk);
    check("rst_mid_cnt", done_cnt, 8'd0);
    check("rst_mid_acc", acc,      4'd0);
    tick();

    // 256 handshaked LOADs wrap the counter.
    do_reset();
    for (int i = 0; i < 256; i++) push(OP_LOAD, 4'(i));
    drain();
    @(negedge clk);
    check("cnt_wrap", done_cnt, 8'd0);
    tick();

    // Randomized traffic with random consumer backpressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        tick();
        res_ready = ($urandom_range(0, 3) != 0);
      end
      push(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    end
    rand_mode = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
